reg_cmd_initiator: RTL and testbench

- Synthesizable register-bus initiator; the requesting end of the regbus protocol whose responder is the testbench regbus memory.
- Accepts read/write commands on a valid/ready stream, queues them, and issues them one at a time on reg_req_o.
- Completes each transfer on reg_rsp_i.ready and returns rdata/error on a valid/ready result stream.
- Used by harnesses and host-side logic to drive regbus slave ports (bootrom, clk_mgr, peripheral configuration).
- Includes a per-transfer timeout so a hung target cannot stall a simulation.

---
 rtl/reg_cmd_initiator_pkg.sv | 34 +++
 rtl/reg_cmd_initiator_fifo.sv | 55 +++++
 rtl/reg_cmd_initiator.sv | 124 ++++++++++++
 tb/tb_reg_cmd_initiator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_initiator_pkg.sv
// Shared types for the regbus command initiator: FSM encoding and the
// default 48-bit address / 32-bit data regbus structs.
package reg_cmd_initiator_pkg;

    localparam int unsigned RegAw = 48;
    localparam int unsigned RegDw = 32;

    typedef logic [1:0] state_e;
    localparam state_e IDLE = 2'd0;
    localparam state_e REQ  = 2'd1;
    localparam state_e RESP = 2'd2;

    typedef struct packed {
        logic [RegAw-1:0]   addr;
        logic               write;
        logic [RegDw-1:0]   wdata;
        logic [RegDw/8-1:0] wstrb;
        logic               valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [RegDw-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_a48_d32_rsp_t;

    typedef struct packed {
        logic [RegAw-1:0]   addr;
        logic               write;
        logic [RegDw-1:0]   wdata;
        logic [RegDw/8-1:0] wstrb;
    } reg_a48_d32_cmd_t;

endpackage

// File: rtl/reg_cmd_initiator_fifo.sv
// Command queue: power-of-two depth, naturally wrapping pointers,
// registered full/empty flags so the upstream ready has no pop path.
module reg_cmd_initiator_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic [Width-1:0] wdata,
    input  logic            pop,
    output logic [Width-1:0] rdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign count_d = count_q + CntW'(do_push) - CntW'(do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/reg_cmd_initiator.sv
// Regbus initiator: queues read/write commands and issues them one at a
// time, returning rdata/error (or a timeout) on an in-order result stream.
module reg_cmd_initiator
    import reg_cmd_initiator_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned CmdDepth      = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type req_t = reg_a48_d32_req_t,
    parameter type rsp_t = reg_a48_d32_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic                   cmd_write_i,
    input  logic [DataWidth-1:0]   cmd_wdata_i,
    input  logic [DataWidth/8-1:0] cmd_wstrb_i,
    output req_t                   reg_req_o,
    input  rsp_t                   reg_rsp_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [DataWidth-1:0]   res_rdata_o,
    output logic                   res_error_o,
    output logic                   res_timeout_o,
    output logic                   busy_o
);

    localparam int unsigned CntW = $clog2(CmdDepth) + 1;
    localparam logic [31:0] TmoLast = 32'(TimeoutCycles - 1);

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   write;
        logic [DataWidth-1:0]   wdata;
        logic [DataWidth/8-1:0] wstrb;
    } cmd_t;

    cmd_t            cmd_in, head;
    logic            fifo_full, fifo_empty, pop;
    logic [CntW-1:0] fifo_count;

    state_e               state_q;
    logic [31:0]          tmo_cnt_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q, timeout_q;
    logic                 in_req, tmo_fire;

    assign cmd_in = '{addr: cmd_addr_i, write: cmd_write_i, wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};

    reg_cmd_initiator_fifo #(
        .Depth (CmdDepth),
        .Width ($bits(cmd_t))
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (cmd_valid_i),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_req   = (state_q == REQ);
    // A ready in the expiry cycle still completes the transfer normally.
    assign tmo_fire = (TimeoutCycles != 0) && in_req && !reg_rsp_i.ready && (tmo_cnt_q == TmoLast);
    assign pop      = in_req && (reg_rsp_i.ready || tmo_fire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!fifo_empty) state_q <= REQ;
                REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (reg_rsp_i.ready) begin
                        rdata_q   <= head.write ? '0 : reg_rsp_i.rdata;
                        error_q   <= reg_rsp_i.error;
                        timeout_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (tmo_fire) begin
                        rdata_q   <= '0;
                        error_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: if (res_ready_i) begin
                    tmo_cnt_q <= '0;
                    state_q   <= fifo_empty ? IDLE : REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_req_o = '0;
        if (in_req) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = head.addr;
            reg_req_o.write = head.write;
            reg_req_o.wdata = head.wdata;
            reg_req_o.wstrb = head.wstrb;
        end
    end

    assign cmd_ready_o   = !fifo_full;
    assign res_valid_o   = (state_q == RESP);
    assign res_rdata_o   = rdata_q;
    assign res_error_o   = error_q;
    assign res_timeout_o = timeout_q;
    assign busy_o        = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_reg_cmd_initiator.sv
// Directed bench for reg_cmd_initiator against a small regbus memory responder.
module tb_reg_cmd_initiator;
    import reg_cmd_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [47:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        res_valid, res_ready = 1'b0, res_error, res_timeout, busy;
    logic [31:0] res_rdata;
    reg_a48_d32_req_t req;
    reg_a48_d32_rsp_t rsp;

    int total = 0, bad = 0;

    // responder knobs
    int          rsp_delay = 0;
    bit          rsp_never = 1'b0;
    logic [47:0] err_addr  = '1;
    int          wcnt;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    reg_cmd_initiator #(
        .AddrWidth(48), .DataWidth(32), .CmdDepth(4), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_write_i(cmd_write),
        .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .reg_req_o(req), .reg_rsp_i(rsp),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_rdata_o(res_rdata), .res_error_o(res_error),
        .res_timeout_o(res_timeout), .busy_o(busy)
    );

    always @(posedge clk) begin
        if (rst || !req.valid || rsp.ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[1] <= 32'hDEAD_BEEF;
        end else if (rsp.ready && req.write) begin
            for (int b = 0; b < 4; b++)
                if (req.wstrb[b]) mem[req.addr[15:12]][8*b +: 8] <= req.wdata[8*b +: 8];
        end
    end

    // rdata is returned even for writes so the initiator's zeroing is visible
    always_comb begin
        rsp = '0;
        if (req.valid && !rsp_never && wcnt >= rsp_delay) begin
            rsp.ready = 1'b1;
            rsp.error = (req.addr == err_addr);
            rsp.rdata = mem[req.addr[15:12]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [47:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        total++; if (req !== '0) begin bad++; $display("FAIL reset_req got=%h want=0", req); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        total++; if ({res_rdata, res_error, res_timeout} !== 34'h0) begin bad++;
            $display("FAIL reset_res_fields got=%h/%b/%b want=0", res_rdata, res_error, res_timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_single_read();
        int n;
        rsp_delay = 3;
        set_cmd(48'h1000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        total++; if (req.valid !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL read_t1 got valid=%b busy=%b want valid=0 busy=1", req.valid, busy); end
        tick();
        total++; if (req.valid !== 1'b1 || req.addr !== 48'h1000 || req.write !== 1'b0) begin bad++;
            $display("FAIL read_t2_req got v=%b a=%h w=%b want v=1 a=1000 w=0", req.valid, req.addr, req.write); end
        n = 0;
        while (!rsp.ready && n < 20) begin tick(); n++; end
        total++; if (n != 3) begin bad++; $display("FAIL read_ready_delay got=%0d want=3", n); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL read_res_early got=%b want=0", res_valid); end
        tick();
        total++; if (res_valid !== 1'b1 || res_rdata !== 32'hDEAD_BEEF || res_error !== 1'b0 || res_timeout !== 1'b0) begin bad++;
            $display("FAIL read_result got v=%b d=%h e=%b t=%b want v=1 d=deadbeef e=0 t=0", res_valid, res_rdata, res_error, res_timeout); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL read_done got v=%b busy=%b want 0/0", res_valid, busy); end
    endtask

    task automatic test_write_readback();
        logic [31:0] exp_wd [2];
        logic [3:0]  exp_st [2];
        logic [31:0] exp_rd [2];
        int idx;
        bit prev_hs;
        exp_wd[0] = 32'hA5A5_A5A5; exp_wd[1] = 32'h0;
        exp_st[0] = 4'hF;          exp_st[1] = 4'h0;
        exp_rd[0] = 32'h0;         exp_rd[1] = 32'hA5A5_A5A5;
        rsp_delay = 1; res_ready = 1'b1;
        set_cmd(48'h2000, 1'b1, 32'hA5A5_A5A5, 4'hF); tick();
        set_cmd(48'h2000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        idx = 0; prev_hs = 1'b0;
        for (int c = 0; c < 40 && idx < 2; c++) begin
            if (prev_hs && idx == 1) begin
                total++; if (req.valid !== 1'b1) begin bad++; $display("FAIL wr_next_issue got=%b want=1", req.valid); end
            end
            prev_hs = 1'b0;
            if (req.valid) begin
                total++;
                if (req.addr !== 48'h2000 || req.write !== (idx == 0) || req.wdata !== exp_wd[idx] || req.wstrb !== exp_st[idx]) begin
                    bad++;
                    $display("FAIL wr_req_stable%0d got a=%h w=%b d=%h s=%h want a=2000 w=%b d=%h s=%h",
                             idx, req.addr, req.write, req.wdata, req.wstrb, idx == 0, exp_wd[idx], exp_st[idx]);
                end
            end
            if (res_valid) begin
                total++;
                if (res_rdata !== exp_rd[idx] || res_error !== 1'b0 || res_timeout !== 1'b0) begin bad++;
                    $display("FAIL wr_result%0d got d=%h e=%b t=%b want d=%h e=0 t=0", idx, res_rdata, res_error, res_timeout, exp_rd[idx]); end
                idx++; prev_hs = 1'b1;
            end
            tick();
        end
        res_ready = 1'b0;
        total++; if (idx != 2) begin bad++; $display("FAIL wr_results_count got=%0d want=2", idx); end
    endtask

    task automatic test_target_error();
        int n;
        err_addr = 48'h3000; rsp_delay = 0;
        set_cmd(48'h3000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        total++; if (res_valid !== 1'b1 || res_error !== 1'b1 || res_timeout !== 1'b0) begin bad++;
            $display("FAIL err_result got v=%b e=%b t=%b want v=1 e=1 t=0", res_valid, res_error, res_timeout); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        err_addr = '1;
    endtask

    task automatic test_timeout();
        int vcnt;
        rsp_never = 1'b1; rsp_delay = 0;
        set_cmd(48'h5000, 1'b0, 32'h0, 4'h0); tick();
        set_cmd(48'h6000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 40 && !res_valid; c++) begin
            if (req.valid) vcnt++;
            tick();
        end
        total++; if (vcnt != 16) begin bad++; $display("FAIL tmo_valid_cycles got=%0d want=16", vcnt); end
        total++; if (res_valid !== 1'b1 || res_rdata !== 32'h0 || res_error !== 1'b1 || res_timeout !== 1'b1 || req.valid !== 1'b0) begin bad++;
            $display("FAIL tmo_result got v=%b d=%h e=%b t=%b rq=%b want v=1 d=0 e=1 t=1 rq=0",
                     res_valid, res_rdata, res_error, res_timeout, req.valid); end
        rsp_never = 1'b0;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        total++; if (req.valid !== 1'b1 || req.addr !== 48'h6000) begin bad++;
            $display("FAIL tmo_next_issue got v=%b a=%h want v=1 a=6000", req.valid, req.addr); end
        tick();
        total++; if (res_valid !== 1'b1 || res_rdata !== 32'hC0DE_0006 || res_timeout !== 1'b0 || res_error !== 1'b0) begin bad++;
            $display("FAIL tmo_next_result got v=%b d=%h e=%b t=%b want v=1 d=c0de0006 e=0 t=0", res_valid, res_rdata, res_error, res_timeout); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int idx;
        rsp_never = 1'b1; rsp_delay = 0; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(48'h4000 + (48'(i) << 12), 1'b0, 32'h0, 4'h0); tick();
            total++; if (cmd_ready !== (i < 3)) begin bad++; $display("FAIL bp_ready_after%0d got=%b want=%b", i, cmd_ready, i < 3); end
        end
        set_cmd(48'h8000, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full_hold%0d got=%b want=0", i, cmd_ready); end
        end
        rsp_never = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", cmd_ready); end
        tick(); cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_refull got=%b want=0", cmd_ready); end
        res_ready = 1'b1; idx = 0;
        for (int c = 0; c < 60 && idx < 5; c++) begin
            if (res_valid) begin
                total++;
                if (res_rdata !== (32'hC0DE_0004 + 32'(idx)) || res_timeout !== 1'b0) begin bad++;
                    $display("FAIL bp_order%0d got d=%h t=%b want d=%h t=0", idx, res_rdata, res_timeout, 32'hC0DE_0004 + 32'(idx)); end
                idx++;
            end
            tick();
        end
        res_ready = 1'b0;
        total++; if (idx != 5) begin bad++; $display("FAIL bp_results_count got=%0d want=5", idx); end
    endtask

    task automatic test_reset_mid();
        rsp_never = 1'b1;
        set_cmd(48'h7000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        tick(); tick();
        total++; if (req.valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b want=1", req.valid); end
        set_cmd(48'h9000, 1'b0, 32'h0, 4'h0); tick(); cmd_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (req.valid !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL rst_mid got rq=%b rv=%b cr=%b busy=%b want 0/0/1/0", req.valid, res_valid, cmd_ready, busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (req.valid !== 1'b0 || res_valid !== 1'b0) begin bad++;
                $display("FAIL rst_quiet%0d got rq=%b rv=%b want 0/0", i, req.valid, res_valid); end
        end
        rsp_never = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_target_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
